// File: rtl/loader_pkg.sv
// Shared types and address-sequencing helpers for the boot image loader.
// The helpers work on plain ints so every parameter set shares one copy.
package loader_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      WRITE,
      DONE
   } loaderState_e;

   typedef struct packed {
      logic [31:0] region;
      logic [31:0] addr;
      logic        last;
   } seqPos_t;

   function automatic int firstAddr(
      int r, int hEn, int hReg, int hStart, int hEnd
   );
      if (hEn != 0 && r == hReg && hStart == 0)
         return hEnd + 1;
      return 0;
   endfunction

   // Lowest region at or above startReg that still holds a loadable word.
   function automatic seqPos_t firstPos(
      int startReg, int nReg, int depth,
      int hEn, int hReg, int hStart, int hEnd
   );
      seqPos_t p;
      p.region = '0;
      p.addr   = '0;
      p.last   = 1'b1;
      for (int r = nReg - 1; r >= 0; r--) begin
         if (r >= startReg &&
             firstAddr(r, hEn, hReg, hStart, hEnd) < depth) begin
            p.region = r;
            p.addr   = firstAddr(r, hEn, hReg, hStart, hEnd);
            p.last   = 1'b0;
         end
      end
      return p;
   endfunction

   function automatic seqPos_t nextPos(
      int region, int addr, int nReg, int depth,
      int hEn, int hReg, int hStart, int hEnd
   );
      seqPos_t p;
      int nxt;
      nxt = addr + 1;
      if (hEn != 0 && region == hReg && nxt == hStart)
         nxt = hEnd + 1;
      if (nxt < depth) begin
         p.region = region;
         p.addr   = nxt;
         p.last   = 1'b0;
      end else begin
         p = firstPos(region + 1, nReg, depth,
                      hEn, hReg, hStart, hEnd);
      end
      return p;
   endfunction

endpackage

// File: rtl/loader_addr_seq.sv
// Region/word-address counters for the loader, including the hole skip.
// `last` flags that the current word is the final one of the image.
module loader_addr_seq
   import loader_pkg::*;
#(
   parameter int ADDR_W       = 10,
   parameter int RIDX_W       = 1,
   parameter int NUM_REGIONS  = 2,
   parameter int REGION_DEPTH = 1024,
   parameter int HOLE_EN      = 1,
   parameter int HOLE_REGION  = 1,
   parameter int HOLE_START   = 192,
   parameter int HOLE_END     = 255
) (
   input  logic              clk,
   input  logic              clkEn,
   input  logic              syncRst,
   input  logic              load,
   input  logic              advance,
   output logic [RIDX_W-1:0] region,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   seqPos_t nxt;
   seqPos_t first;

   always_comb begin
      nxt = nextPos(int'(region), int'(addr), NUM_REGIONS,
                    REGION_DEPTH, HOLE_EN, HOLE_REGION,
                    HOLE_START, HOLE_END);
      first = firstPos(0, NUM_REGIONS, REGION_DEPTH, HOLE_EN,
                       HOLE_REGION, HOLE_START, HOLE_END);
   end

   assign last = nxt.last;

   always_ff @(posedge clk) begin
      if (syncRst) begin
         region <= '0;
         addr   <= '0;
      end else if (clkEn) begin
         if (load && !first.last) begin
            region <= RIDX_W'(first.region);
            addr   <= ADDR_W'(first.addr);
         end else if (advance && !nxt.last) begin
            region <= RIDX_W'(nxt.region);
            addr   <= ADDR_W'(nxt.addr);
         end
      end
   end

endmodule

// File: rtl/boot_image_loader.sv
// Copies the boot ROM image into the target memories, one word per
// fetch/write pair, and releases the core once the last word lands.
module boot_image_loader
   import loader_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int ADDR_W       = 10,
   parameter int NUM_REGIONS  = 2,
   parameter int REGION_DEPTH = 1024,
   parameter int HOLE_EN      = 1,
   parameter int HOLE_REGION  = 1,
   parameter int HOLE_START   = 192,
   parameter int HOLE_END     = 255,
   localparam int RIDX_W =
      (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
   input  logic                     clk,
   input  logic                     clk_en,
   input  logic                     sync_rst,
   input  logic                     flash_start,
   output logic                     rom_rd_en,
   output logic [RIDX_W+ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0]        rom_data,
   output logic                     wr_valid,
   input  logic                     wr_ready,
   output logic [RIDX_W-1:0]        wr_region,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [DATA_W-1:0]        wr_data,
   output logic                     busy,
   output logic                     system_enable
);

   if (HOLE_START > HOLE_END || HOLE_END >= REGION_DEPTH ||
       HOLE_REGION >= NUM_REGIONS ||
       REGION_DEPTH > (1 << ADDR_W)) begin : gBadCfg
      $error("boot_image_loader: invalid region/hole parameters");
   end

   loaderState_e      state;
   logic [DATA_W-1:0] dataReg;
   logic              firstWr;
   logic              last;
   logic              load;
   logic              advance;
   logic [RIDX_W-1:0] region;
   logic [ADDR_W-1:0] addr;

   assign load = clk_en && flash_start &&
                 (state == IDLE || state == DONE);
   assign advance = clk_en && wr_ready && state == WRITE;

   loader_addr_seq #(
      .ADDR_W      (ADDR_W),
      .RIDX_W      (RIDX_W),
      .NUM_REGIONS (NUM_REGIONS),
      .REGION_DEPTH(REGION_DEPTH),
      .HOLE_EN     (HOLE_EN),
      .HOLE_REGION (HOLE_REGION),
      .HOLE_START  (HOLE_START),
      .HOLE_END    (HOLE_END)
   ) uSeq (
      .clk    (clk),
      .clkEn  (clk_en),
      .syncRst(sync_rst),
      .load   (load),
      .advance(advance),
      .region (region),
      .addr   (addr),
      .last   (last)
   );

   assign rom_addr  = {region, addr};
   assign wr_region = region;
   assign wr_addr   = addr;
   // ROM data arrives in the first write cycle; bypass it until latched.
   assign wr_data   = firstWr ? rom_data : dataReg;

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state         <= IDLE;
         busy          <= 1'b0;
         system_enable <= 1'b0;
         wr_valid      <= 1'b0;
         rom_rd_en     <= 1'b0;
         firstWr       <= 1'b0;
         dataReg       <= '0;
      end else if (clk_en) begin
         firstWr <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (flash_start) begin
                  state         <= FETCH;
                  rom_rd_en     <= 1'b1;
                  busy          <= 1'b1;
                  system_enable <= 1'b0;
               end
            end
            FETCH: begin
               state     <= WRITE;
               rom_rd_en <= 1'b0;
               wr_valid  <= 1'b1;
               firstWr   <= 1'b1;
            end
            WRITE: begin
               if (firstWr)
                  dataReg <= rom_data;
               if (wr_ready) begin
                  wr_valid <= 1'b0;
                  if (last) begin
                     state         <= DONE;
                     busy          <= 1'b0;
                     system_enable <= 1'b1;
                  end else begin
                     state     <= FETCH;
                     rom_rd_en <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_boot_image_loader.sv
// Bench for boot_image_loader: random ROM contents, backpressure,
// clock-enable gaps, reflash and mid-flash reset on small regions.
module tb_boot_image_loader;

   typedef logic [19:0] ent_t;
   typedef ent_t entQ_t[$];

   logic        clk = 1'b0;
   logic        clkEn, syncRst, flashStart, wrReady;
   logic        romRdEn, wrValid, busy, sysEn;
   logic [3:0]  romAddr;
   logic [15:0] romData, wrData;
   logic        wrRegion;
   logic [2:0]  wrAddr;
   logic        auxRst, auxStart;

   logic [15:0] rom [16];
   ent_t        got[$];
   int          holeReads = 0;
   int          nVec = 0;
   int          nFail = 0;

   always #5 clk = ~clk;

   boot_image_loader #(
      .DATA_W(16), .ADDR_W(3), .NUM_REGIONS(2),
      .REGION_DEPTH(8), .HOLE_EN(1), .HOLE_REGION(1),
      .HOLE_START(2), .HOLE_END(4)
   ) dut (
      .clk(clk), .clk_en(clkEn), .sync_rst(syncRst),
      .flash_start(flashStart), .rom_rd_en(romRdEn),
      .rom_addr(romAddr), .rom_data(romData),
      .wr_valid(wrValid), .wr_ready(wrReady),
      .wr_region(wrRegion), .wr_addr(wrAddr), .wr_data(wrData),
      .busy(busy), .system_enable(sysEn)
   );

   always @(posedge clk) begin
      if (clkEn && romRdEn) begin
         romData <= rom[romAddr];
         if (romAddr[3] && romAddr[2:0] >= 3'd2 &&
             romAddr[2:0] <= 3'd4)
            holeReads <= holeReads + 1;
      end
      if (clkEn && !syncRst && wrValid && wrReady)
         got.push_back({wrRegion, wrAddr, wrData});
   end

   // Extra configurations: no hole, hole at start, hole at end.
   for (genvar g = 0; g < 3; g++) begin : gAux
      localparam int HEN = (g == 0) ? 0 : 1;
      localparam int HS  = (g == 1) ? 0 : 5;
      localparam int HE  = (g == 1) ? 4 : 7;
      logic        rd, wv, se, bz, wreg;
      logic [3:0]  ra;
      logic [2:0]  wa;
      logic [15:0] romQ, wd;
      ent_t        q[$];

      boot_image_loader #(
         .DATA_W(16), .ADDR_W(3), .NUM_REGIONS(2),
         .REGION_DEPTH(8), .HOLE_EN(HEN), .HOLE_REGION(1),
         .HOLE_START(HS), .HOLE_END(HE)
      ) uAux (
         .clk(clk), .clk_en(1'b1), .sync_rst(auxRst),
         .flash_start(auxStart), .rom_rd_en(rd),
         .rom_addr(ra), .rom_data(romQ),
         .wr_valid(wv), .wr_ready(1'b1),
         .wr_region(wreg), .wr_addr(wa), .wr_data(wd),
         .busy(bz), .system_enable(se)
      );

      always @(posedge clk) begin
         if (rd) romQ <= rom[ra];
         if (!auxRst && wv) q.push_back({wreg, wa, wd});
      end
   end

   function automatic entQ_t expSeq(bit hEn, int hs, int he);
      entQ_t e;
      for (int r = 0; r < 2; r++)
         for (int a = 0; a < 8; a++)
            if (!(hEn && r == 1 && a >= hs && a <= he))
               e.push_back({1'(r), 3'(a), rom[r * 8 + a]});
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chkSeq(input string tag, input entQ_t g,
                         input entQ_t e);
      chk({tag, "_len"}, g.size(), e.size());
      for (int i = 0; i < e.size() && i < g.size(); i++)
         chk(tag, 32'(g[i]), 32'(e[i]));
   endtask

   function automatic logic [31:0] snap();
      return {8'h0, busy, sysEn, wrValid, romRdEn, romAddr, wrData};
   endfunction

   task automatic runFlash(input int stallAt, input bit randEn,
                           input int rstAt, output int enCyc,
                           output int stalls);
      int stallLeft;
      bit lastEn, doneSeen;
      logic [31:0] prevSnap, held;
      stallLeft = 3;
      lastEn = 1'b1;
      doneSeen = 1'b0;
      enCyc = 0;
      stalls = 0;
      held = '0;
      got.delete();
      @(negedge clk);
      clkEn = 1'b1;
      wrReady = 1'b1;
      flashStart = 1'b1;
      @(posedge clk);
      #1 flashStart = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_sysen", sysEn, 0);
      chk("start_rd", romRdEn, 1);
      chk("start_addr", romAddr, 0);
      prevSnap = snap();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (!lastEn) chk("hold", snap(), prevSnap);
         prevSnap = snap();
         if (sysEn) begin
            doneSeen = 1'b1;
            break;
         end
         if (rstAt >= 0 && got.size() == rstAt && wrValid) begin
            clkEn = 1'b1;
            wrReady = 1'b1;
            syncRst = 1'b1;
            @(posedge clk);
            #1;
            chk("rst_outs", {busy, sysEn, wrValid, romRdEn}, 0);
            chk("rst_addr", romAddr, 0);
            chk("rst_nowrite", got.size(), rstAt);
            syncRst = 1'b0;
            return;
         end
         clkEn = randEn ? 1'($urandom % 2) : 1'b1;
         if (stallAt >= 0 && got.size() == stallAt && wrValid &&
             stallLeft > 0) begin
            wrReady = 1'b0;
            if (stallLeft == 3)
               held = {wrValid, 11'h0, wrAddr, wrData};
            else
               chk("stall_stable", {wrValid, 11'h0, wrAddr, wrData},
                   held);
            stallLeft--;
         end else begin
            wrReady = randEn ? 1'($urandom % 2) : 1'b1;
         end
         if (clkEn && wrValid && !wrReady) stalls++;
         lastEn = clkEn;
         @(posedge clk);
         if (clkEn) enCyc++;
      end
      chk("done_seen", doneSeen, 1);
   endtask

   initial begin
      int n, s;
      entQ_t e;
      for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
      clkEn = 1'b1;
      syncRst = 1'b1;
      flashStart = 1'b0;
      wrReady = 1'b1;
      auxRst = 1'b1;
      auxStart = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", {busy, sysEn, wrValid, romRdEn}, 0);
      chk("reset_addr", romAddr, 0);
      chk("reset_data", wrData, 0);
      syncRst = 1'b0;
      auxRst = 1'b0;

      auxStart = 1'b1;
      @(posedge clk);
      #1 auxStart = 1'b0;
      n = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (gAux[0].se) break;
         @(posedge clk);
         n++;
      end
      chk("basic_cycles", n, 32);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("aux_done", {gAux[0].se, gAux[1].se, gAux[2].se}, 3'b111);
      chkSeq("basic_seq", gAux[0].q, expSeq(0, 0, 0));
      chkSeq("hole0_seq", gAux[1].q, expSeq(1, 0, 4));
      chkSeq("hole7_seq", gAux[2].q, expSeq(1, 5, 7));

      e = expSeq(1, 2, 4);
      chk("exp_count", e.size(), 13);
      runFlash(-1, 0, -1, n, s);
      chk("hole_cycles", n, 26);
      chkSeq("hole_seq", got, e);
      chk("hole_reads", holeReads, 0);
      chk("done_sysen", sysEn, 1);

      runFlash(4, 0, -1, n, s);
      chk("bp_stalls", s, 3);
      chk("bp_cycles", n, 29);
      chkSeq("bp_seq", got, e);

      runFlash(-1, 1, -1, n, s);
      chk("en_cycles", n, 26 + s);
      chkSeq("en_seq", got, e);

      runFlash(-1, 0, 6, n, s);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("idle_after_rst", {busy, sysEn, wrValid, romRdEn}, 0);
      runFlash(-1, 0, -1, n, s);
      chk("rf_cycles", n, 26);
      chkSeq("rf_seq", got, e);
      chk("final_hole_reads", holeReads, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               nVec, nFail);
      $finish;
   end

endmodule
